pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 28 ++
 rtl/pipeline_controller_sat_counter.sv | 25 ++
 rtl/pipeline_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline hazard/halt controller: FSM state
// encodings, drain length, counter widths and the load-use hazard compare.
package pipeline_controller_pkg;

  localparam int GRP_ADDR_WIDTH  = 5;
  localparam int DRAIN_CYCLES    = 3;
  localparam int DRAIN_CNT_WIDTH = 2;
  localparam int PERF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    DRAIN      = 2'd2,
    HALT       = 2'd3
  } state_t;

  // A load in EX whose destination feeds either source of the instruction in
  // ID. Register 0 is compared like any other register.
  function automatic logic load_use_hazard(
    input logic                      is_load,
    input logic [GRP_ADDR_WIDTH-1:0] ex_rt,
    input logic [GRP_ADDR_WIDTH-1:0] id_rs,
    input logic [GRP_ADDR_WIDTH-1:0] id_rt
  );
    return is_load && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, zero on clr.
  // NOTE: async reset in the sensitivity list and <= for every state update;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline control: load-use stall, jump/branch flush, halt drain and two
// saturating performance counters. Control outputs are Mealy (same cycle).
module pipeline_controller
  import pipeline_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ID_EX_is_load,
  input  logic [GRP_ADDR_WIDTH-1:0] ID_EX_rt,
  input  logic [GRP_ADDR_WIDTH-1:0] IF_ID_rs,
  input  logic [GRP_ADDR_WIDTH-1:0] IF_ID_rt,
  input  logic                      is_jump,
  input  logic                      branch_taken,
  input  logic                      halt_req,
  input  logic                      resume,
  input  logic                      clear_counters,
  output logic                      stall_pipeline,
  output logic                      bubble_id_ex,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      halted,
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0] flush_events
);

  state_t                     state, state_nxt;
  logic [DRAIN_CNT_WIDTH-1:0] drain_cnt, drain_cnt_nxt;
  logic                       hazard;
  logic                       stall_c, bubble_c, flush_if_c, flush_ex_c, halted_c;

  assign hazard = load_use_hazard(ID_EX_is_load, ID_EX_rt, IF_ID_rs, IF_ID_rt);

  // Next state and control outputs from state plus current events.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall_c       = 1'b0;
    bubble_c      = 1'b0;
    flush_if_c    = 1'b0;
    flush_ex_c    = 1'b0;
    halted_c      = 1'b0;
    unique case (state)
      RUN: begin
        if (branch_taken) begin
          flush_if_c = 1'b1;
          flush_ex_c = 1'b1;
        end else if (is_jump) begin
          flush_if_c = 1'b1;
        end else if (hazard) begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = LOAD_STALL;
        end else if (halt_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_CNT_WIDTH'(DRAIN_CYCLES);
        end
      end
      LOAD_STALL: begin
        // Single stall cycle; a second hazard check here would double-stall.
        if (branch_taken) begin
          flush_if_c = 1'b1;
          flush_ex_c = 1'b1;
        end
        state_nxt = RUN;
      end
      DRAIN: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (branch_taken) begin
          flush_if_c = 1'b1;
          flush_ex_c = 1'b1;
        end
        if (drain_cnt == DRAIN_CNT_WIDTH'(1)) begin
          state_nxt     = HALT;
          drain_cnt_nxt = '0;
        end else begin
          drain_cnt_nxt = drain_cnt - DRAIN_CNT_WIDTH'(1);
        end
      end
      HALT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        halted_c = 1'b1;
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Outputs are forced low while reset is held, regardless of event inputs.
  assign stall_pipeline = rst & stall_c;
  assign bubble_id_ex   = rst & bubble_c;
  assign flush_if_id    = rst & flush_if_c;
  assign flush_id_ex    = rst & flush_ex_c;
  assign halted         = rst & halted_c;

  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_pipeline),
    .clr   (clear_counters),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_if_id),
    .clr   (clear_counters),
    .count (flush_events)
  );

endmodule
